// File: rtl/rv32i_dmem_bridge.sv
// Data-memory bridge: turns single-cycle execute-stage load/store strobes into
// wait-stated Avalon-MM transactions, stalling the pipeline until each completes.
module rv32i_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] addr,
  input  logic [3:0]  st_be,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        stall,
  output logic        bus_err,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [31:0]      avm_address_nxt, avm_writedata_nxt, ld_data_nxt;
  logic [3:0]       avm_byteenable_nxt;
  logic             avm_read_nxt, avm_write_nxt, ld_valid_nxt, bus_err_nxt;
  logic             tmo_hit;
  logic [31:0]      addr_word;

  // tmo_cnt counts the busy cycles already spent in the current state, so the
  // current cycle is the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1.
  assign tmo_hit   = (tmo_cnt >= CNT_LIMIT);
  assign addr_word = addr & 32'hFFFF_FFFC;
  assign stall     = (state != IDLE);

  always_comb begin
    state_nxt          = state;
    avm_address_nxt    = avm_address;
    avm_byteenable_nxt = avm_byteenable;
    avm_writedata_nxt  = avm_writedata;
    avm_read_nxt       = avm_read;
    avm_write_nxt      = avm_write;
    ld_data_nxt        = ld_data;
    ld_valid_nxt       = 1'b0;
    bus_err_nxt        = 1'b0;
    tmo_cnt_nxt        = (tmo_cnt == CNT_MAX) ? tmo_cnt : tmo_cnt + CNT_W'(1);

    unique case (state)
      IDLE: begin
        tmo_cnt_nxt = '0;
        if (store) begin
          avm_address_nxt    = addr_word;
          avm_byteenable_nxt = st_be;
          avm_writedata_nxt  = wdata;
          avm_write_nxt      = 1'b1;
          state_nxt          = WR_REQ;
        end else if (load) begin
          avm_address_nxt    = addr_word;
          avm_byteenable_nxt = 4'hF;
          avm_read_nxt       = 1'b1;
          state_nxt          = RD_REQ;
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          avm_write_nxt = 1'b0;
          state_nxt     = IDLE;
        end else if (tmo_hit) begin
          avm_write_nxt = 1'b0;
          bus_err_nxt   = 1'b1;
          state_nxt     = IDLE;
        end
      end
      RD_REQ: begin
        // An accepted request is progress, so it outranks a coincident timeout.
        if (!avm_waitrequest) begin
          avm_read_nxt = 1'b0;
          if (avm_readdatavalid) begin
            ld_data_nxt  = avm_readdata;
            ld_valid_nxt = 1'b1;
            state_nxt    = IDLE;
          end else begin
            tmo_cnt_nxt = '0;
            state_nxt   = RD_DATA;
          end
        end else if (tmo_hit) begin
          avm_read_nxt = 1'b0;
          ld_data_nxt  = ERR_RDATA;
          ld_valid_nxt = 1'b1;
          bus_err_nxt  = 1'b1;
          state_nxt    = IDLE;
        end
      end
      RD_DATA: begin
        if (avm_readdatavalid) begin
          ld_data_nxt  = avm_readdata;
          ld_valid_nxt = 1'b1;
          state_nxt    = IDLE;
        end else if (tmo_hit) begin
          ld_data_nxt  = ERR_RDATA;
          ld_valid_nxt = 1'b1;
          bus_err_nxt  = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      ld_data        <= '0;
      ld_valid       <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      state          <= state_nxt;
      tmo_cnt        <= tmo_cnt_nxt;
      avm_address    <= avm_address_nxt;
      avm_byteenable <= avm_byteenable_nxt;
      avm_writedata  <= avm_writedata_nxt;
      avm_read       <= avm_read_nxt;
      avm_write      <= avm_write_nxt;
      ld_data        <= ld_data_nxt;
      ld_valid       <= ld_valid_nxt;
      bus_err        <= bus_err_nxt;
    end
  end

  // Upstream must never present load and store together; store wins if it does.
  a_no_collide: assert property (@(posedge clk) disable iff (reset)
    (state == IDLE) |-> !(load && store))
    else $warning("rv32i_dmem_bridge: load and store strobed together, load dropped");

endmodule

// File: tb/tb_rv32i_dmem_bridge.sv
// Randomized bench for rv32i_dmem_bridge: a per-transaction outcome model predicts
// stall length, bus request window, completion/abort and returned data.
module tb_rv32i_dmem_bridge;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        load, store;
  logic [31:0] addr;
  logic [3:0]  st_be;
  logic [31:0] wdata;
  logic [31:0] ld_data;
  logic        ld_valid, stall, bus_err;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ld_model = 32'h0;

  rv32i_dmem_bridge #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset(reset), .load(load), .store(store), .addr(addr),
    .st_be(st_be), .wdata(wdata), .ld_data(ld_data), .ld_valid(ld_valid),
    .stall(stall), .bus_err(bus_err), .avm_address(avm_address),
    .avm_byteenable(avm_byteenable), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge of an idle cycle; returns at the negedge of the idle
  // cycle after the transaction, having checked its completion outputs there.
  // w = waitrequest cycles before acceptance, d = read-data latency after it.
  task automatic do_txn(input logic is_st, input logic is_ld, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] rdata, input int w, input int d);
    logic is_wr;
    logic accepted, err;
    int   req_len, total;
    is_wr    = is_st;
    accepted = (w + 1 <= T);
    req_len  = accepted ? w + 1 : T;
    if (is_wr || !accepted || d == 0) begin
      total = req_len;
      err   = !accepted;
    end else begin
      total = w + 1 + ((d <= T) ? d : T);
      err   = (d > T);
    end

    store = is_st; load = is_ld; addr = a; st_be = be; wdata = wd;
    avm_waitrequest = 1'b1;
    avm_readdatavalid = 1'($urandom_range(0, 1));
    avm_readdata = $urandom;
    @(posedge clk);
    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      check_eq("busy_stall", stall, 1'b1);
      check_eq("busy_ld_valid", ld_valid, 1'b0);
      check_eq("busy_bus_err", bus_err, 1'b0);
      if (is_wr) begin
        check_eq("wr_req", avm_write, 1'b1);
        check_eq("wr_no_read", avm_read, 1'b0);
        check_eq("wr_addr", avm_address, a & 32'hFFFF_FFFC);
        check_eq("wr_be", avm_byteenable, be);
        check_eq("wr_data", avm_writedata, wd);
      end else begin
        check_eq("rd_no_write", avm_write, 1'b0);
        check_eq("rd_req", avm_read, (i <= req_len) ? 1'b1 : 1'b0);
        if (i <= req_len) begin
          check_eq("rd_addr", avm_address, a & 32'hFFFF_FFFC);
          check_eq("rd_be", avm_byteenable, 4'hF);
        end
      end
      // Strobes and address wiggle under stall and must be ignored.
      store = 1'($urandom_range(0, 1));
      load  = 1'($urandom_range(0, 1));
      addr  = $urandom;
      avm_readdata = $urandom;
      if (i <= w) begin
        avm_waitrequest   = 1'b1;
        avm_readdatavalid = 1'($urandom_range(0, 1));
      end else begin
        avm_waitrequest = (i == w + 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (is_wr) avm_readdatavalid = 1'($urandom_range(0, 1));
        else       avm_readdatavalid = (i == w + 1 + d) ? 1'b1 : 1'b0;
        if (!is_wr && i == w + 1 + d) avm_readdata = rdata;
      end
      @(posedge clk);
    end
    @(negedge clk);
    if (!is_wr) ld_model = err ? ERR : rdata;
    check_eq("done_stall", stall, 1'b0);
    check_eq("done_read", avm_read, 1'b0);
    check_eq("done_write", avm_write, 1'b0);
    check_eq("done_bus_err", bus_err, err);
    check_eq("done_ld_valid", ld_valid, !is_wr);
    check_eq("done_ld_data", ld_data, ld_model);
    store = 1'b0; load = 1'b0;
    avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_stall", stall, 1'b0);
      check_eq("idle_ld_valid", ld_valid, 1'b0);
      check_eq("idle_ld_data", ld_data, ld_model);
    end
  endtask

  task automatic reset_mid_read(input logic into_data);
    load = 1'b1; addr = 32'h0000_0300;
    avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    avm_waitrequest = into_data ? 1'b0 : 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_stall", stall, 1'b1);
    check_eq("pre_rst_read", avm_read, into_data ? 1'b0 : 1'b1);
    reset = 1'b1;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0;
    ld_model = 32'h0;
    check_eq("rst_read", avm_read, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_ld_data", ld_data, 32'h0);
    check_eq("rst_ld_valid", ld_valid, 1'b0);
    check_eq("rst_bus_err", bus_err, 1'b0);
    check_eq("rst_addr", avm_address, 32'h0);
    idle_cycles(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = 1'b0; store = 1'b0; addr = '0; st_be = '0; wdata = '0;
    avm_waitrequest = 1'b1; avm_readdata = '0; avm_readdatavalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_stall", stall, 1'b0);
    check_eq("reset_read", avm_read, 1'b0);
    check_eq("reset_write", avm_write, 1'b0);
    check_eq("reset_ld_data", ld_data, 32'h0);
    check_eq("reset_ld_valid", ld_valid, 1'b0);
    check_eq("reset_bus_err", bus_err, 1'b0);
    check_eq("reset_addr", avm_address, 32'h0);
    check_eq("reset_be", avm_byteenable, 4'h0);
    check_eq("reset_wdata", avm_writedata, 32'h0);
    reset = 1'b0;
    idle_cycles(1);

    do_txn(1'b1, 1'b0, 32'h0000_1006, 4'b1100, 32'hBEEF_0000, 32'h0, 0, 0);
    idle_cycles(1);
    do_txn(1'b0, 1'b1, 32'h0000_0200, 4'h0, 32'h0, 32'h1234_5678, 3, 2);
    do_txn(1'b0, 1'b1, 32'h0000_0404, 4'h0, 32'h0, 32'h0BAD_CAFE, 0, 0);
    do_txn(1'b0, 1'b1, 32'h0000_0500, 4'h0, 32'h0, 32'h5555_AAAA, 100, 0);
    do_txn(1'b1, 1'b0, 32'h0000_0600, 4'hF, 32'h1111_2222, 32'h0, 100, 0);
    do_txn(1'b0, 1'b1, 32'h0000_0700, 4'h0, 32'h0, 32'h7777_0000, 0, 6);
    do_txn(1'b0, 1'b1, 32'h0000_0800, 4'h0, 32'h0, 32'h8888_0001, 1, T);
    do_txn(1'b1, 1'b0, 32'h0000_0900, 4'h3, 32'h0000_9999, 32'h0, T - 1, 0);
    idle_cycles(1);
    reset_mid_read(1'b1);
    reset_mid_read(1'b0);

    do_txn(1'b1, 1'b0, 32'h0000_0A00, 4'b0011, 32'h0000_ABCD, 32'h0, 1, 0);
    do_txn(1'b0, 1'b1, 32'h0000_0B00, 4'h0, 32'h0, 32'hB0B0_B0B0, 0, 1);
    do_txn(1'b1, 1'b1, 32'h0000_0C02, 4'b0110, 32'h00C0_C000, 32'h0, 0, 0);
    idle_cycles(1);

    for (int n = 0; n < 60; n++) begin
      logic st;
      st = 1'($urandom_range(0, 1));
      do_txn(st, !st, $urandom, 4'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
